// File: rtl/cond_move_wb_pipe.sv
// E/M/W write-back carrier for ALU writes and conditional moves (movz/movn).
// Move conditions resolve in E against forwarded rt; $0 writes are suppressed there.
module cond_move_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush_e,
   input  logic              d_valid,
   input  logic              d_regwrite,
   input  logic [1:0]        d_cond_type,
   input  logic [4:0]        d_rd,
   input  logic [DATA_W-1:0] e_rs_val,
   input  logic [DATA_W-1:0] e_rt_val,
   input  logic [DATA_W-1:0] e_alu_res,
   output logic [4:0]        e_a3,
   output logic [DATA_W-1:0] e_wd,
   output logic [4:0]        m_a3,
   output logic [DATA_W-1:0] m_wd,
   output logic [4:0]        w_a3,
   output logic [DATA_W-1:0] w_wd,
   output logic              w_we,
   output logic [CNT_W-1:0]  squash_cnt
);

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_MOVZ   = 2'b01;
   localparam logic [1:0] COND_MOVN   = 2'b10;

   logic              e_valid;
   logic              e_regwrite;
   logic [1:0]        e_cond_type;
   logic [4:0]        e_rd;

   logic              rt_zero;
   logic              is_move;
   logic              cond_ok;
   logic              rd_nonzero;
   logic              we_e;
   logic              squash_e;

   logic              m_we;
   logic [4:0]        w_a3_q;

   // A stall or flush turns the incoming slot into a bubble; only valid matters then.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid     <= 1'b0;
         e_regwrite  <= 1'b0;
         e_cond_type <= 2'b00;
         e_rd        <= 5'd0;
      end else begin
         e_valid     <= d_valid & ~(stall | flush_e);
         e_regwrite  <= d_regwrite;
         e_cond_type <= d_cond_type;
         e_rd        <= d_rd;
      end
   end

   always_comb begin
      rt_zero    = (e_rt_val == '0);
      is_move    = (e_cond_type == COND_MOVZ) || (e_cond_type == COND_MOVN);
      rd_nonzero = (e_rd != 5'd0);
      cond_ok    = (e_cond_type == COND_ALWAYS) ||
                   ((e_cond_type == COND_MOVZ) && rt_zero) ||
                   ((e_cond_type == COND_MOVN) && !rt_zero);
      we_e       = e_valid & e_regwrite & cond_ok & rd_nonzero;
      squash_e   = e_valid & e_regwrite & is_move & ~cond_ok & rd_nonzero;
      e_a3       = we_e ? e_rd : 5'd0;
      e_wd       = is_move ? e_rs_val : e_alu_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_a3   <= 5'd0;
         m_wd   <= '0;
         m_we   <= 1'b0;
         w_a3_q <= 5'd0;
         w_wd   <= '0;
         w_we   <= 1'b0;
      end else begin
         m_a3   <= e_a3;
         m_wd   <= e_wd;
         m_we   <= we_e;
         w_a3_q <= m_a3;
         w_wd   <= m_wd;
         w_we   <= m_we;
      end
   end

   assign w_a3 = w_we ? w_a3_q : 5'd0;

   // Saturating count of moves that reached E with a failing condition.
   always_ff @(posedge clk) begin
      if (reset) begin
         squash_cnt <= '0;
      end else if (squash_e && (squash_cnt != {CNT_W{1'b1}})) begin
         squash_cnt <= squash_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cond_move_wb_pipe.sv
// Randomized bench for cond_move_wb_pipe with a queue-based reference model
// plus directed scenarios carrying hand-computed expectations.
module tb_cond_move_wb_pipe;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              reset;
   logic              stall;
   logic              flush_e;
   logic              d_valid;
   logic              d_regwrite;
   logic [1:0]        d_cond_type;
   logic [4:0]        d_rd;
   logic [DATA_W-1:0] e_rs_val;
   logic [DATA_W-1:0] e_rt_val;
   logic [DATA_W-1:0] e_alu_res;
   logic [4:0]        e_a3;
   logic [DATA_W-1:0] e_wd;
   logic [4:0]        m_a3;
   logic [DATA_W-1:0] m_wd;
   logic [4:0]        w_a3;
   logic [DATA_W-1:0] w_wd;
   logic              w_we;
   logic [CNT_W-1:0]  squash_cnt;

   cond_move_wb_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush_e(flush_e),
      .d_valid(d_valid), .d_regwrite(d_regwrite), .d_cond_type(d_cond_type),
      .d_rd(d_rd), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
      .e_alu_res(e_alu_res), .e_a3(e_a3), .e_wd(e_wd), .m_a3(m_a3),
      .m_wd(m_wd), .w_a3(w_a3), .w_wd(w_wd), .w_we(w_we),
      .squash_cnt(squash_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       valid;
      bit       regwrite;
      bit [1:0] ctype;
      bit [4:0] rd;
   } instr_t;

   typedef struct {
      bit              we;
      bit [4:0]        a3;
      bit [DATA_W-1:0] wd;
      bit              squashed;
   } wr_t;

   int     checks   = 0;
   int     failures = 0;
   instr_t mdlE;
   wr_t    mdlPipe[$];
   int     mdlCnt;

   function automatic wr_t resolve(instr_t i, bit [DATA_W-1:0] rs,
                                   bit [DATA_W-1:0] rt, bit [DATA_W-1:0] alu);
      wr_t r;
      bit  isMove = (i.ctype == 2'd1) || (i.ctype == 2'd2);
      bit  pass = (i.ctype == 2'd0) || (i.ctype == 2'd1 && rt == 0) ||
                  (i.ctype == 2'd2 && rt != 0);
      bit  live = i.valid && i.regwrite && i.rd != 0;
      r.we       = live && pass;
      r.a3       = r.we ? i.rd : 5'd0;
      r.wd       = isMove ? rs : alu;
      r.squashed = live && isMove && !pass;
      return r;
   endfunction

   task automatic expectEq(input string name, input logic [DATA_W-1:0] act,
                           input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit st, input bit fl,
                                input bit dv, input bit drw, input bit [1:0] ct,
                                input bit [4:0] rd, input bit [DATA_W-1:0] rs,
                                input bit [DATA_W-1:0] rt, input bit [DATA_W-1:0] alu);
      reset = rst; stall = st; flush_e = fl;
      d_valid = dv; d_regwrite = drw; d_cond_type = ct; d_rd = rd;
      e_rs_val = rs; e_rt_val = rt; e_alu_res = alu;
      #1;
   endtask

   task automatic checkOutput();
      wr_t eExp;
      eExp = resolve(mdlE, e_rs_val, e_rt_val, e_alu_res);
      expectEq("e_a3", e_a3, eExp.a3);
      if (eExp.we) expectEq("e_wd", e_wd, eExp.wd);
      expectEq("m_a3", m_a3, mdlPipe[0].a3);
      if (mdlPipe[0].we) expectEq("m_wd", m_wd, mdlPipe[0].wd);
      expectEq("w_we", w_we, mdlPipe[1].we);
      expectEq("w_a3", w_a3, mdlPipe[1].a3);
      if (mdlPipe[1].we) expectEq("w_wd", w_wd, mdlPipe[1].wd);
      expectEq("squash_cnt", squash_cnt, mdlCnt);
   endtask

   task automatic tick();
      wr_t eRes;
      instr_t nxt;
      @(posedge clk);
      eRes = resolve(mdlE, e_rs_val, e_rt_val, e_alu_res);
      nxt.valid = d_valid && !stall && !flush_e;
      nxt.regwrite = d_regwrite; nxt.ctype = d_cond_type; nxt.rd = d_rd;
      if (reset) begin
         mdlE = '{default: 0};
         mdlPipe = '{'{default: 0}, '{default: 0}};
         mdlCnt = 0;
      end else begin
         if (eRes.squashed && mdlCnt < (1 << CNT_W) - 1) mdlCnt++;
         mdlPipe.push_front(eRes);
         void'(mdlPipe.pop_back());
         mdlE = nxt;
      end
      @(negedge clk);
   endtask

   task automatic idleCycle(input bit [DATA_W-1:0] rs, input bit [DATA_W-1:0] rt);
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 5'd0, rs, rt, 32'h0);
      checkOutput();
   endtask

   initial begin
      mdlE = '{default: 0};
      mdlPipe = '{'{default: 0}, '{default: 0}};
      mdlCnt = 0;
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 5'd0, 0, 0, 0);
      tick();

      // Reset state
      idleCycle(0, 0);
      expectEq("lit_reset_w_we", w_we, 0);
      expectEq("lit_reset_cnt", squash_cnt, 0);

      // movz rd=8 with rt=0 writes rs two edges after E
      applyStimulus(0, 0, 0, 1, 1, 2'd1, 5'd8, 0, 0, 0); checkOutput(); tick();
      idleCycle(32'h1234, 0);
      expectEq("lit_movz_e_a3", e_a3, 8);
      tick();
      idleCycle(0, 0); tick();
      idleCycle(0, 0);
      expectEq("lit_movz_w_we", w_we, 1);
      expectEq("lit_movz_w_a3", w_a3, 8);
      expectEq("lit_movz_w_wd", w_wd, 32'h1234);
      expectEq("lit_movz_cnt", squash_cnt, 0);
      tick();

      // movz rd=9 rt=5 squashes; movn with the same operands writes
      applyStimulus(0, 0, 0, 1, 1, 2'd1, 5'd9, 0, 0, 0); checkOutput(); tick();
      applyStimulus(0, 0, 0, 1, 1, 2'd2, 5'd9, 32'hBEEF, 5, 0); checkOutput();
      expectEq("lit_squash_e_a3", e_a3, 0);
      tick();
      idleCycle(32'hBEEF, 5);
      expectEq("lit_squash_cnt", squash_cnt, 1);
      expectEq("lit_movn_e_a3", e_a3, 9);
      tick();
      idleCycle(0, 0);
      expectEq("lit_squash_w_we", w_we, 0);
      tick();
      idleCycle(0, 0);
      expectEq("lit_movn_w_a3", w_a3, 9);
      expectEq("lit_movn_w_wd", w_wd, 32'hBEEF);
      tick();

      // Unconditional write to $0 is suppressed and not counted
      applyStimulus(0, 0, 0, 1, 1, 2'd0, 5'd0, 0, 0, 0); checkOutput(); tick();
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 5'd0, 0, 0, 32'hFFFF); checkOutput();
      expectEq("lit_r0_e_a3", e_a3, 0);
      tick();
      for (int i = 0; i < 2; i++) begin idleCycle(0, 0); tick(); end
      idleCycle(0, 0);
      expectEq("lit_r0_w_we", w_we, 0);
      expectEq("lit_r0_cnt", squash_cnt, 1);

      // Stall then flush each insert a bubble ahead of a valid movz
      applyStimulus(0, 1, 0, 1, 1, 2'd1, 5'd7, 0, 0, 0); checkOutput(); tick();
      applyStimulus(0, 0, 1, 1, 1, 2'd1, 5'd7, 0, 0, 0); checkOutput();
      expectEq("lit_stall_e_a3", e_a3, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 1, 2'd1, 5'd7, 0, 0, 0); checkOutput();
      expectEq("lit_flush_e_a3", e_a3, 0);
      expectEq("lit_stall_m_a3", m_a3, 0);
      tick();
      idleCycle(32'h77, 0);
      expectEq("lit_resume_e_a3", e_a3, 7);
      tick();
      idleCycle(0, 0); tick();
      idleCycle(0, 0);
      expectEq("lit_resume_w_a3", w_a3, 7);
      expectEq("lit_resume_w_wd", w_wd, 32'h77);
      tick();

      // Saturation: sixteen failing movn (rt=0) from a count of 1
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 2'd2, 5'd4, 0, 0, 0); checkOutput(); tick();
      end
      idleCycle(0, 0); tick();
      idleCycle(0, 0);
      expectEq("lit_sat_cnt", squash_cnt, 4'hF);

      // Reset while a writing movn sits in M
      applyStimulus(0, 0, 0, 1, 1, 2'd2, 5'd3, 0, 0, 0); checkOutput(); tick();
      idleCycle(32'hABCD, 1); tick();
      expectEq("lit_inflight_m_a3", m_a3, 3);
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 5'd0, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         idleCycle(0, 0);
         expectEq("lit_rst_w_we", w_we, 0);
         expectEq("lit_rst_w_a3", w_a3, 0);
         expectEq("lit_rst_cnt", squash_cnt, 0);
         tick();
      end

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit [DATA_W-1:0] rt = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
         applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 80,
                       $urandom_range(0, 99) < 85, 2'($urandom_range(0, 3)),
                       5'($urandom_range(0, 5)), $urandom, rt, $urandom);
         if (!reset) checkOutput();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
